// File: rtl/ame_num_approx_pipe.sv
// ame_num_approx_pipe: multi-lane leading-one exponent approximator with a
// per-frame block exponent. The pipeline has two stages with valid/ready and
// full backpressure. Stage 1 holds the lane magnitudes and flags. Stage 2
// holds the exponents and the frame maximum.
module ame_num_approx_pipe #(
  parameter  int DATA_BITS = 64,
  parameter  int LANES     = 4,
  localparam int EXP_BITS  = $clog2(DATA_BITS) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  logic                          in_last_i,
  input  logic                          in_mode_i,
  input  logic [LANES*DATA_BITS-1:0]    in_data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic                          out_last_o,
  output logic [LANES*EXP_BITS-1:0]     out_exp_o,
  output logic [LANES-1:0]              out_zero_o,
  output logic [LANES-1:0]              out_sign_o,
  output logic [EXP_BITS-1:0]           out_blk_exp_o
);

  localparam int NBYTES = DATA_BITS / 8;

  // Highest set bit of m. Each byte is OR-reduced, the highest non-empty
  // byte is selected, and then an 8-bit priority encode runs inside it.
  function automatic logic [EXP_BITS-1:0] floor_exp(input logic [DATA_BITS-1:0] m);
    logic [NBYTES-1:0]   grp;
    logic [7:0]          sel;
    logic [EXP_BITS-1:0] base;
    logic [2:0]          bidx;
    grp  = '0;
    sel  = m[7:0];
    base = '0;
    bidx = '0;
    for (int g = 0; g < NBYTES; g++) grp[g] = |m[g*8 +: 8];
    for (int g = 0; g < NBYTES; g++) begin
      if (grp[g]) begin
        base = EXP_BITS'(g * 8);
        sel  = m[g*8 +: 8];
      end
    end
    for (int b = 0; b < 8; b++) if (sel[b]) bidx = 3'(b);
    return base + EXP_BITS'(bidx);
  endfunction

  // In round-to-nearest mode, the exponent rounds up when the bit just below
  // the leading one is set, which means m >= 1.5 * 2^p.
  function automatic logic [EXP_BITS-1:0] round_exp(input logic [DATA_BITS-1:0] m,
                                                    input logic [EXP_BITS-1:0]  p,
                                                    input logic                 mode);
    logic [DATA_BITS-1:0] sh;
    sh = '0;
    if (mode && (p != '0)) begin
      sh = m >> (p - EXP_BITS'(1));
      if (sh[0]) return p + EXP_BITS'(1);
    end
    return p;
  endfunction

  logic                       vld_p1, vld_p2;
  logic                       adv1, adv2;
  logic [LANES*DATA_BITS-1:0] mag_c, mag_p1;
  logic [LANES-1:0]           sign_c, zero_c, sign_p1, zero_p1;
  logic                       mode_p1, last_p1;
  logic [LANES*EXP_BITS-1:0]  exp_c, exp_p2;
  logic [EXP_BITS-1:0]        beat_max, blk_c, run_max, blk_p2;
  logic [LANES-1:0]           sign_p2, zero_p2;
  logic                       last_p2;

  assign adv2       = !vld_p2 || out_ready_i;
  assign adv1       = !vld_p1 || adv2;
  assign in_ready_o = adv1;

  // Lane magnitudes and flags, taken from the input beat.
  always_comb begin
    logic [DATA_BITS-1:0] x;
    x      = '0;
    mag_c  = '0;
    sign_c = '0;
    zero_c = '0;
    for (int k = 0; k < LANES; k++) begin
      x = in_data_i[k*DATA_BITS +: DATA_BITS];
      mag_c[k*DATA_BITS +: DATA_BITS] = x[DATA_BITS-1] ? (~x + DATA_BITS'(1)) : x;
      sign_c[k] = x[DATA_BITS-1];
      zero_c[k] = (x == '0);
    end
  end

  // ---- stage 1 boundary ----
  // Stage 1 valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i)     vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= in_valid_i;
  end

  // Stage 1 data loads only when an input beat is accepted.
  always_ff @(posedge clk_i) begin
    if (adv1 && in_valid_i) begin
      mag_p1  <= mag_c;
      sign_p1 <= sign_c;
      zero_p1 <= zero_c;
      mode_p1 <= in_mode_i;
      last_p1 <= in_last_i;
    end
  end

  // Per-lane exponents, the beat maximum, and the running frame maximum.
  always_comb begin
    logic [EXP_BITS-1:0] e;
    e        = '0;
    exp_c    = '0;
    beat_max = '0;
    for (int k = 0; k < LANES; k++) begin
      e = round_exp(mag_p1[k*DATA_BITS +: DATA_BITS],
                    floor_exp(mag_p1[k*DATA_BITS +: DATA_BITS]), mode_p1);
      exp_c[k*EXP_BITS +: EXP_BITS] = e;
      if (e > beat_max) beat_max = e;
    end
    blk_c = (run_max > beat_max) ? run_max : beat_max;
  end

  // ---- stage 2 boundary ----
  // The running maximum accumulates across a frame and clears after the last beat.
  always_ff @(posedge clk_i) begin
    if (rst_i)                run_max <= '0;
    else if (adv2 && vld_p1)  run_max <= last_p1 ? '0 : blk_c;
  end

  // Stage 2 holds the result beat. It is cleared on reset so the outputs read 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      exp_p2  <= '0;
      zero_p2 <= '0;
      sign_p2 <= '0;
      last_p2 <= 1'b0;
      blk_p2  <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        exp_p2  <= exp_c;
        zero_p2 <= zero_p1;
        sign_p2 <= sign_p1;
        last_p2 <= last_p1;
        blk_p2  <= last_p1 ? blk_c : '0;
      end
    end
  end

  assign out_valid_o   = vld_p2;
  assign out_last_o    = last_p2;
  assign out_exp_o     = exp_p2;
  assign out_zero_o    = zero_p2;
  assign out_sign_o    = sign_p2;
  assign out_blk_exp_o = (vld_p2 && last_p2) ? blk_p2 : '0;

endmodule

// File: tb/tb_ame_num_approx_pipe.sv
// Testbench for ame_num_approx_pipe: directed beats with known exponents,
// backpressure, mid-frame reset, and a randomized valid/ready run scored
// against an arithmetic reference model.
module tb_ame_num_approx_pipe;
  localparam int DB = 64;
  localparam int LN = 4;
  localparam int EB = 7;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_last, in_mode;
  logic [LN*DB-1:0]   in_data;
  logic               out_valid, out_ready, out_last;
  logic [LN*EB-1:0]   out_exp;
  logic [LN-1:0]      out_zero, out_sign;
  logic [EB-1:0]      out_blk;

  always #5 clk = ~clk;

  ame_num_approx_pipe #(.DATA_BITS(DB), .LANES(LN)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_last_i(in_last),
    .in_mode_i(in_mode), .in_data_i(in_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_last_o(out_last),
    .out_exp_o(out_exp), .out_zero_o(out_zero), .out_sign_o(out_sign),
    .out_blk_exp_o(out_blk)
  );

  typedef struct {
    logic [LN*EB-1:0] exp;
    logic [LN-1:0]    zero;
    logic [LN-1:0]    sign;
    logic             last;
    logic [EB-1:0]    blk;
  } beat_t;

  beat_t       q[$];
  beat_t       got[$];
  int          tests = 0;
  int          fails = 0;
  int          fmax  = 0;
  bit          in_fired, out_fired, s_in_ready, s_out_valid, held_v;
  logic [43:0] held;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Exponent from plain arithmetic: floor(log2 m), then +1 when m >= 1.5*2^p.
  function automatic int ref_exp(input logic [DB-1:0] m, input bit mode);
    int          p;
    logic [DB:0] th;
    if (m == '0) return 0;
    p = 0;
    while ((m >> (p + 1)) != '0) p++;
    if (mode && p > 0) begin
      th = 65'(3) << (p - 1);
      if ({1'b0, m} >= th) p++;
    end
    return p;
  endfunction

  task automatic model_push();
    beat_t         b;
    logic [DB-1:0] x, m;
    int            e, bm, blk;
    bm = 0;
    b.exp = '0; b.zero = '0; b.sign = '0;
    for (int k = 0; k < LN; k++) begin
      x = in_data[k*DB +: DB];
      m = x[DB-1] ? (DB'(0) - x) : x;
      e = ref_exp(m, in_mode);
      b.exp[k*EB +: EB] = EB'(e);
      b.zero[k] = (m == '0);
      b.sign[k] = ($signed(x) < 0);
      if (e > bm) bm = e;
    end
    blk    = (fmax > bm) ? fmax : bm;
    b.last = in_last;
    b.blk  = in_last ? EB'(blk) : '0;
    fmax   = in_last ? 0 : blk;
    q.push_back(b);
  endtask

  // One clock cycle: settle, sample, score handshakes, then advance to the next negedge.
  task automatic cycle();
    beat_t e;
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    in_fired    = in_valid && in_ready && !rst;
    out_fired   = out_valid && out_ready && !rst;
    if (held_v && !rst) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_fields", 64'({out_exp, out_zero, out_sign, out_last, out_blk}), 64'(held));
    end
    held_v = out_valid && !out_ready && !rst;
    held   = {out_exp, out_zero, out_sign, out_last, out_blk};
    if (out_fired) begin
      chk("beat_expected", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("exp",  64'(out_exp),  64'(e.exp));
        chk("zero", 64'(out_zero), 64'(e.zero));
        chk("sign", 64'(out_sign), 64'(e.sign));
        chk("last", 64'(out_last), 64'(e.last));
        chk("blk",  64'(out_blk),  64'(e.blk));
      end
      e.exp = out_exp; e.zero = out_zero; e.sign = out_sign; e.last = out_last; e.blk = out_blk;
      got.push_back(e);
    end
    if (in_fired) model_push();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [LN*DB-1:0] d, input logic mode, input logic last);
    int n;
    in_data = d; in_mode = mode; in_last = last; in_valid = 1'b1;
    n = 0;
    do begin cycle(); n++; end while (!in_fired && n < 50);
    chk("send_accepted", 64'(in_fired), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() != 0 && n < 50) begin cycle(); n++; end
    chk("drain_empty", 64'(q.size()), 64'(0));
  endtask

  function automatic logic [DB-1:0] rand_lane();
    logic [DB-1:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(5, 0))
      0:       return '0;
      1:       return 64'h8000_0000_0000_0000;
      2:       return r;
      3:       return r >> $urandom_range(63, 0);
      4:       return DB'(0) - DB'($urandom_range(100, 1));
      default: return (DB'(3) << $urandom_range(61, 0)) - DB'($urandom_range(1, 0));
    endcase
  endfunction

  task automatic new_beat();
    for (int k = 0; k < LN; k++) in_data[k*DB +: DB] = rand_lane();
    in_mode = 1'($urandom_range(1, 0));
    in_last = ($urandom_range(3, 0) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, sent, cyc;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b1;
    held_v = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_last",  64'(out_last),  64'(0));
    chk("rst_out_exp",   64'(out_exp),   64'(0));
    chk("rst_out_zero",  64'(out_zero),  64'(0));
    chk("rst_out_sign",  64'(out_sign),  64'(0));
    chk("rst_out_blk",   64'(out_blk),   64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));

    // Beat {1,-1,0,min} in floor mode, with output latency checked.
    got.delete();
    send({64'h8000_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1}, 1'b0, 1'b1);
    cycle();
    chk("lat_not_yet", 64'(s_out_valid), 64'(0));
    cycle();
    chk("lat_valid", 64'(s_out_valid), 64'(1));
    drain();
    chk("t1_count", 64'(got.size()), 64'(1));
    if (got.size() == 1) begin
      chk("t1_exp",  64'(got[0].exp),  64'({7'd63, 7'd0, 7'd0, 7'd0}));
      chk("t1_zero", 64'(got[0].zero), 64'(4'b0100));
      chk("t1_sign", 64'(got[0].sign), 64'(4'b1010));
      chk("t1_blk",  64'(got[0].blk),  64'(63));
    end

    // The same data in round mode, then in floor mode.
    got.delete();
    send({64'd12, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd3}, 1'b1, 1'b1);
    send({64'd12, 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 64'd3}, 1'b0, 1'b1);
    drain();
    chk("t2_count", 64'(got.size()), 64'(2));
    if (got.size() == 2) begin
      chk("t2_round_exp", 64'(got[0].exp), 64'({7'd4, 7'd63, 7'd1, 7'd2}));
      chk("t2_round_blk", 64'(got[0].blk), 64'(63));
      chk("t2_floor_exp", 64'(got[1].exp), 64'({7'd3, 7'd62, 7'd1, 7'd1}));
      chk("t2_floor_blk", 64'(got[1].blk), 64'(62));
    end

    // A 3-beat frame with maxima 5, 17, 9, then a 1-beat frame with maximum 2.
    got.delete();
    send({64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1 << 5}, 1'b0, 1'b0);
    send({64'd0, -(64'd1 << 17), 64'd1, 64'd0}, 1'b0, 1'b0);
    send({64'd1 << 9, 64'd0, 64'd0, 64'd7}, 1'b0, 1'b1);
    send({64'd4, 64'd0, 64'd0, 64'd1}, 1'b0, 1'b1);
    drain();
    chk("t3_count", 64'(got.size()), 64'(4));
    if (got.size() == 4) begin
      chk("t3_blk_b1", 64'(got[0].blk), 64'(0));
      chk("t3_blk_b2", 64'(got[1].blk), 64'(0));
      chk("t3_blk_b3", 64'(got[2].blk), 64'(17));
      chk("t3_blk_f2", 64'(got[3].blk), 64'(2));
    end

    // Fill the pipe while the output is stalled, then release it for one cycle.
    cnt = 0;
    out_ready = 1'b0;
    new_beat();
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      if (in_fired) begin cnt++; new_beat(); end
    end
    chk("bp_accepts", 64'(cnt), 64'(2));
    cycle();
    chk("bp_full_ready", 64'(s_in_ready), 64'(0));
    chk("bp_full_noacc", 64'(in_fired), 64'(0));
    out_ready = 1'b1;
    cycle();
    chk("bp_out_fire", 64'(out_fired), 64'(1));
    chk("bp_in_fire",  64'(in_fired),  64'(1));
    if (in_fired) new_beat();
    out_ready = 1'b0;
    cycle();
    chk("bp_refull_ready", 64'(s_in_ready), 64'(0));
    drain();

    // Reset in the middle of a frame, then a clean 1-beat frame.
    got.delete();
    send({64'd0, 64'd0, 64'd1 << 40, 64'd0}, 1'b0, 1'b0);
    out_ready = 1'b0;
    cycle();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    fmax = 0;
    held_v = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    send({64'd0, 64'd8, 64'd0, 64'd0}, 1'b0, 1'b1);
    drain();
    repeat (3) cycle();
    chk("mid_rst_count", 64'(got.size()), 64'(1));
    if (got.size() == 1) chk("mid_rst_blk", 64'(got[0].blk), 64'(3));

    // Randomized valid/ready traffic checked against the model.
    sent = 0;
    cyc  = 0;
    in_valid = 1'b0;
    while ((sent < 1000 || q.size() != 0 || in_valid) && cyc < 20000) begin
      if (!in_valid && sent < 1000 && $urandom_range(1, 0) == 1) begin
        new_beat();
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(1, 0));
      cycle();
      cyc++;
      if (in_fired) begin sent++; in_valid = 1'b0; end
    end
    chk("rand_sent",    64'(sent),     64'(1000));
    chk("rand_drained", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
